// File: rtl/rv32_div_pkg.sv
// ---------------------------------------------------------------------------
// rv32_div_pkg
// Shared types and constants for the RV32M divide sequencer:
//   div_state_t        FSM state encoding (IDLE / RUN / DONE)
//   DIV_OVF_DIVIDEND   most-negative dividend that overflows against -1
//   DIV_ALL_ONES       quotient returned for divide-by-zero
//   div_is_div_op()    true for DIV/DIVU/REM/REMU control codes
//   div_is_signed_op() true for DIV/REM
//   div_is_rem_op()    true for REM/REMU
// ---------------------------------------------------------------------------
`include "defines_header.svh"

package rv32_div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_t;

    localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
    localparam logic [31:0] DIV_ALL_ONES     = 32'hFFFF_FFFF;

    function automatic logic div_is_div_op(input logic [`ALU_CONTROL_WIDTH-1:0] ctl);
        return (ctl == `ALU_DIV) || (ctl == `ALU_DIVU) ||
               (ctl == `ALU_REM) || (ctl == `ALU_REMU);
    endfunction

    function automatic logic div_is_signed_op(input logic [`ALU_CONTROL_WIDTH-1:0] ctl);
        return (ctl == `ALU_DIV) || (ctl == `ALU_REM);
    endfunction

    function automatic logic div_is_rem_op(input logic [`ALU_CONTROL_WIDTH-1:0] ctl);
        return (ctl == `ALU_REM) || (ctl == `ALU_REMU);
    endfunction

endpackage

// File: rtl/defines_header.svh
// ---------------------------------------------------------------------------
// defines_header.svh
// Core-wide ALU control codes shared by the decoder, the EX-stage ALU and the
// multi-cycle divide sequencer. Guarded so every file may include it.
// ---------------------------------------------------------------------------
`ifndef DEFINES_HEADER_SVH
`define DEFINES_HEADER_SVH

`define ALU_CONTROL_WIDTH 5

`define ALU_ADD  5'd0
`define ALU_SUB  5'd1
`define ALU_AND  5'd2
`define ALU_OR   5'd3
`define ALU_XOR  5'd4
`define ALU_SLL  5'd5
`define ALU_SRL  5'd6
`define ALU_SRA  5'd7
`define ALU_SLT  5'd8
`define ALU_SLTU 5'd9
`define ALU_MUL  5'd10
`define ALU_MULH 5'd11
`define ALU_DIV  5'd12
`define ALU_DIVU 5'd13
`define ALU_REM  5'd14
`define ALU_REMU 5'd15

`endif

// File: rtl/rv32_e_div_step.sv
// ---------------------------------------------------------------------------
// rv32_e_div_step
// One combinational iteration of a radix-2 restoring divider.
//   rem_i     in  XLEN  partial remainder (always < divisor_i)
//   quo_i     in  XLEN  dividend bits still to be shifted in / quotient so far
//   divisor_i in  XLEN  divisor magnitude
//   rem_o     out XLEN  next partial remainder
//   quo_o     out XLEN  quo_i shifted left with the new quotient bit in bit 0
// ---------------------------------------------------------------------------
module rv32_e_div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          borrow;

    // shifted < 2*divisor, so bit XLEN of the difference is a clean borrow flag
    assign shifted = {rem_i, quo_i[XLEN-1]};
    assign diff    = shifted - {1'b0, divisor_i};
    assign borrow  = diff[XLEN];

    assign rem_o = borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_o = {quo_i[XLEN-2:0], ~borrow};

endmodule

// File: rtl/rv32_e_div_sequencer.sv
// ---------------------------------------------------------------------------
// rv32_e_div_sequencer
// Multi-cycle DIV/DIVU/REM/REMU unit for the execute stage. Runs XLEN
// restoring iterations on operand magnitudes, then applies the sign fixup.
// Divide-by-zero and signed overflow finish in one cycle.
//   clk_i          in   core clock
//   rst_ni         in   asynchronous active-low reset
//   start_i        in   valid instruction present in EX
//   alu_control_i  in   decoded ALU op (only divide ops are acted on)
//   src_a_i        in   dividend (rs1)
//   src_b_i        in   divisor  (rs2)
//   flush_i        in   EX flush, aborts any operation
//   busy_o         out  stall request to the hazard unit
//   valid_o        out  result_o valid this cycle (one-cycle pulse)
//   result_o       out  quotient or remainder; holds last value otherwise
// ---------------------------------------------------------------------------
`include "defines_header.svh"

module rv32_e_div_sequencer
    import rv32_div_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    input  logic [`ALU_CONTROL_WIDTH-1:0] alu_control_i,
    input  logic [XLEN-1:0]               src_a_i,
    input  logic [XLEN-1:0]               src_b_i,
    input  logic                          flush_i,
    output logic                          busy_o,
    output logic                          valid_o,
    output logic [XLEN-1:0]               result_o
);

    localparam int unsigned    CNT_W   = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = XLEN'(DIV_OVF_DIVIDEND);

    div_state_t       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [XLEN-1:0]  rem_q,     rem_d;
    logic [XLEN-1:0]  quo_q,     quo_d;
    logic [XLEN-1:0]  dvsr_q,    dvsr_d;
    logic             is_rem_q,  is_rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]  result_q,  result_d;
    logic             valid_q,   valid_d;

    logic             op_div, op_signed, op_rem, launch;
    logic             sign_a, sign_b, div_zero, overflow;
    logic [XLEN-1:0]  abs_a, abs_b;
    logic [XLEN-1:0]  step_rem, step_quo;

    rv32_e_div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvsr_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    assign op_div    = div_is_div_op(alu_control_i);
    assign op_signed = div_is_signed_op(alu_control_i);
    assign op_rem    = div_is_rem_op(alu_control_i);
    assign launch    = (state_q == DIV_IDLE) & start_i & op_div & ~flush_i;

    assign sign_a   = op_signed & src_a_i[XLEN-1];
    assign sign_b   = op_signed & src_b_i[XLEN-1];
    assign abs_a    = sign_a ? (~src_a_i + 1'b1) : src_a_i;
    assign abs_b    = sign_b ? (~src_b_i + 1'b1) : src_b_i;
    assign div_zero = (src_b_i == '0);
    assign overflow = op_signed & (src_a_i == MIN_NEG) & (src_b_i == '1);

    // Combinational so the hazard unit stalls in the very cycle the op is seen
    assign busy_o   = launch | (state_q == DIV_RUN);
    // A flush arriving while the result is presented must squash it
    assign valid_o  = valid_q & ~flush_i;
    assign result_o = result_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        valid_d   = 1'b0;

        unique case (state_q)
            DIV_IDLE: begin
                if (launch) begin
                    is_rem_d  = op_rem;
                    neg_quo_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    rem_d     = '0;
                    quo_d     = abs_a;
                    dvsr_d    = abs_b;
                    if (div_zero) begin
                        result_d = op_rem ? src_a_i : '1;
                        valid_d  = 1'b1;
                        state_d  = DIV_DONE;
                    end else if (overflow) begin
                        result_d = op_rem ? '0 : MIN_NEG;
                        valid_d  = 1'b1;
                        state_d  = DIV_DONE;
                    end else begin
                        cnt_d   = CNT_W'(XLEN - 1);
                        state_d = DIV_RUN;
                    end
                end
            end
            DIV_RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == '0) begin
                    // Sign fixup taken from the final step's outputs directly
                    if (is_rem_q)
                        result_d = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
                    else
                        result_d = neg_quo_q ? (~step_quo + 1'b1) : step_quo;
                    valid_d = 1'b1;
                    state_d = DIV_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase

        if (flush_i) begin
            state_d = DIV_IDLE;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
        end
    end

endmodule

// File: tb/tb_rv32_e_div_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rv32_e_div_sequencer
// Directed and randomized checks of the divide sequencer against an
// arithmetic reference model (native signed/unsigned / and %).
// ---------------------------------------------------------------------------
`include "defines_header.svh"

module tb_rv32_e_div_sequencer;

    localparam logic [31:0] MINV = 32'h8000_0000;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          start = 1'b0;
    logic [`ALU_CONTROL_WIDTH-1:0] ctl = `ALU_ADD;
    logic [31:0]                   src_a = '0;
    logic [31:0]                   src_b = '0;
    logic                          flush = 1'b0;
    logic                          busy_o, valid_o;
    logic [31:0]                   result_o;

    int n_cmp = 0;
    int n_err = 0;

    rv32_e_div_sequencer #(.XLEN(32)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .alu_control_i (ctl),
        .src_a_i       (src_a),
        .src_b_i       (src_b),
        .flush_i       (flush),
        .busy_o        (busy_o),
        .valid_o       (valid_o),
        .result_o      (result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics in plain arithmetic
    function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            `ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            `ALU_REMU: return (b == 0) ? a : a % b;
            `ALU_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
                return sa / sb;
            end
            default: begin
                if (b == 0) return a;
                if (a == MINV && b == 32'hFFFF_FFFF) return 0;
                return sa % sb;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        bit sgn;
        sgn = (op == `ALU_DIV) || (op == `ALU_REM);
        if (b == 0 || (sgn && a == MINV && b == 32'hFFFF_FFFF)) return 1;
        return 33;
    endfunction

    // Issue one op in cycle 0, scramble operands afterwards, and measure the
    // cycle of the valid pulse, the stall length and the number of pulses.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input bit hold);
        int nvalid, nbusy, first;
        logic [31:0] res;
        nvalid = 0;
        nbusy  = 0;
        first  = -1;
        res    = '0;
        @(negedge clk);
        ctl = op; src_a = a; src_b = b; start = 1'b1;
        for (int k = 0; k < 45; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (!hold || first >= 0) start = 1'b0;
                src_a = $urandom;
                src_b = $urandom;
            end
            #1;
            if (busy_o) nbusy++;
            if (valid_o) begin
                nvalid++;
                if (first < 0) begin
                    first = k;
                    res   = result_o;
                end
            end
            if (first >= 0 && k > first + 1) break;
        end
        start = 1'b0;
        chk({tag, ".result"}, res, exp);
        chk({tag, ".latency"}, first, exp_lat);
        chk({tag, ".busy_cycles"}, nbusy, exp_lat);
        chk({tag, ".valid_pulses"}, nvalid, 1);
    endtask

    task automatic watch_quiet(input string tag, input int n);
        int nv, nb;
        nv = 0;
        nb = 0;
        repeat (n) begin
            @(negedge clk);
            #1;
            if (valid_o) nv++;
            if (busy_o) nb++;
        end
        chk({tag, ".valid"}, nv, 0);
        chk({tag, ".busy"}, nb, 0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return MINV;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 200);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [4:0]  op;
        logic [31:0] a, b;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("reset.busy", busy_o, 0);
        chk("reset.valid", valid_o, 0);
        chk("reset.result", result_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed values
        run_op("div_100_7",   `ALU_DIV,  32'd100, 32'd7, 32'd14, 33, 1'b0);
        run_op("rem_100_7",   `ALU_REM,  32'd100, 32'd7, 32'd2,  33, 1'b0);
        run_op("div_m100_7",  `ALU_DIV,  -32'sd100, 32'd7, 32'hFFFF_FFF2, 33, 1'b0);
        run_op("rem_m100_7",  `ALU_REM,  -32'sd100, 32'd7, 32'hFFFF_FFFE, 33, 1'b0);
        run_op("divu_max_2",  `ALU_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 33, 1'b0);
        run_op("div_5_0",     `ALU_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
        run_op("remu_5_0",    `ALU_REMU, 32'd5, 32'd0, 32'd5, 1, 1'b0);
        run_op("div_ovf",     `ALU_DIV,  MINV, 32'hFFFF_FFFF, MINV, 1, 1'b0);
        run_op("rem_ovf",     `ALU_REM,  MINV, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
        run_op("divu_hold",   `ALU_DIVU, 32'd1000, 32'd10, 32'd100, 33, 1'b1);
        run_op("rem_z_hold",  `ALU_REM,  32'd77, 32'd0, 32'd77, 1, 1'b1);

        // Flush at DIV cycle 10
        @(negedge clk);
        ctl = `ALU_DIVU; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        #1;
        chk("flush_mid.busy_start", busy_o, 1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 10) flush = 1'b1;
            #1;
        end
        chk("flush_mid.valid_same", valid_o, 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_mid.busy_next", busy_o, 0);
        chk("flush_mid.valid_next", valid_o, 0);
        watch_quiet("flush_mid.after", 40);
        run_op("divu_9_3", `ALU_DIVU, 32'd9, 32'd3, 32'd3, 33, 1'b0);

        // Flush beats start in the same cycle
        @(negedge clk);
        ctl = `ALU_DIV; src_a = 32'd50; src_b = 32'd5; start = 1'b1; flush = 1'b1;
        #1;
        chk("flush_start.busy", busy_o, 0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        watch_quiet("flush_start.after", 40);

        // Flush while the special-case result is presented
        @(negedge clk);
        ctl = `ALU_DIV; src_a = 32'd5; src_b = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b1;
        #1;
        chk("flush_done.valid", valid_o, 0);
        @(negedge clk);
        flush = 1'b0;
        watch_quiet("flush_done.after", 5);

        // Non-divide op is ignored
        @(negedge clk);
        ctl = `ALU_ADD; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
        #1;
        chk("add.busy", busy_o, 0);
        watch_quiet("add.hold", 40);
        start = 1'b0;

        // Reset in the middle of a division
        @(negedge clk);
        ctl = `ALU_DIV; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.busy", busy_o, 0);
        chk("rst_mid.valid", valid_o, 0);
        chk("rst_mid.result", result_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_quiet("rst_mid.after", 40);

        // Randomized operations against the reference model
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0: op = `ALU_DIV;
                1: op = `ALU_DIVU;
                2: op = `ALU_REM;
                default: op = `ALU_REMU;
            endcase
            a = pick_operand();
            b = pick_operand();
            run_op($sformatf("rnd%0d", i), op, a, b, ref_result(op, a, b),
                   ref_latency(op, a, b), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
